// File: rtl/bytes_to_bridge_pkg.sv
// Shared types for the byte-wide bridge read path.
// Used by bytes_to_bridge and rd_tag_pipe.
package bytes_to_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_e;

  localparam int BYTES_PER_WORD  = 4;
  localparam int MAX_MEM_LATENCY = 4;

  typedef logic [1:0] lane_t;

  localparam lane_t LAST_LANE = lane_t'(BYTES_PER_WORD - 1);

  typedef struct packed {
    logic  valid;
    lane_t lane;
  } rd_tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Latency-matched shift register of {valid, lane} tags.
// The output tag lines up with the memory's returned byte.
module rd_tag_pipe
  import bytes_to_bridge_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clk,
  input  logic    reset_n,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t [DEPTH-1:0] pipe_q;

  generate
    if (DEPTH == 1) begin : g_one
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          pipe_q <= '0;
        end else begin
          pipe_q[0] <= tag_i;
        end
      end
    end else begin : g_many
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          pipe_q <= '0;
        end else begin
          pipe_q <= {pipe_q[DEPTH-2:0], tag_i};
        end
      end
    end
  endgenerate

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/bytes_to_bridge.sv
// 32-bit bridge read built from four byte reads.
// BYTES_TO_BRIDGE_BIG_ENDIAN_EN selects big-endian lanes.
module bytes_to_bridge
  import bytes_to_bridge_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] bridge_addr,
  input  logic        bridge_rd,
  output logic [31:0] bridge_rd_data,
  output logic        bridge_rd_valid,
  output logic        busy,
  output logic [31:0] mem_address,
  output logic        mem_rd,
  input  logic [7:0]  mem_rd_data
);

  state_e      state_q, state_d;
  logic [31:0] base_q;
  lane_t       k_q, k_d;
  logic        mem_rd_q, mem_rd_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  lane_t       lane_d;
  logic [7:0]  lane0_q, lane1_q, lane2_q;
  logic [31:0] rd_data_q, word_d;
  logic        rd_valid_q;
  logic        accept;
  logic        last_cap;
  rd_tag_t     tag_in, tag_out;

  assign accept   = (state_q == IDLE) && bridge_rd;
  assign last_cap = tag_out.valid && (tag_out.lane == LAST_LANE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bridge_rd) state_d = ISSUE;
      ISSUE:   if (k_q == LAST_LANE) state_d = WAIT;
      WAIT:    if (last_cap) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_rd_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    lane_d     = k_q;
    k_d        = k_q;
    unique case (1'b1)
      accept: begin
        mem_rd_d   = 1'b1;
        mem_addr_d = bridge_addr;
        lane_d     = '0;
        k_d        = lane_t'(1);
      end
      (state_q == ISSUE): begin
        mem_rd_d   = 1'b1;
        mem_addr_d = base_q + 32'(k_q);
        k_d        = k_q + lane_t'(1);
      end
      default: ;
    endcase
  end

  assign busy = (state_q != IDLE);

  // Tag enters the pipe on the edge its request is registered
  assign tag_in = '{valid: mem_rd_d, lane: lane_d};

  rd_tag_pipe #(
    .DEPTH (MEM_LATENCY)
  ) u_tag_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .tag_i   (tag_in),
    .tag_o   (tag_out)
  );

`ifdef BYTES_TO_BRIDGE_BIG_ENDIAN_EN
  assign word_d = {lane0_q, lane1_q, lane2_q, mem_rd_data};
`else
  assign word_d = {mem_rd_data, lane2_q, lane1_q, lane0_q};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q     <= '0;
      k_q        <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      lane0_q    <= '0;
      lane1_q    <= '0;
      lane2_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (accept) base_q <= bridge_addr;
      k_q        <= k_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      if (tag_out.valid) begin
        case (tag_out.lane)
          2'd0:    lane0_q <= mem_rd_data;
          2'd1:    lane1_q <= mem_rd_data;
          2'd2:    lane2_q <= mem_rd_data;
          default: ;
        endcase
      end
      rd_valid_q <= last_cap;
      if (last_cap) rd_data_q <= word_d;
    end
  end

  assign mem_rd          = mem_rd_q;
  assign mem_address     = mem_addr_q;
  assign bridge_rd_data  = rd_data_q;
  assign bridge_rd_valid = rd_valid_q;

endmodule

// File: tb/tb_bytes_to_bridge.sv
// Randomised scoreboard bench for bytes_to_bridge.
// Reference model predicts byte requests, words and busy windows.
module tb_bytes_to_bridge;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] bridge_addr;
  logic        bridge_rd;
  logic [31:0] bridge_rd_data;
  logic        bridge_rd_valid;
  logic        busy;
  logic [31:0] mem_address;
  logic        mem_rd;
  logic [7:0]  mem_rd_data;

  bytes_to_bridge #(
    .MEM_LATENCY (LAT)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .bridge_addr     (bridge_addr),
    .bridge_rd       (bridge_rd),
    .bridge_rd_data  (bridge_rd_data),
    .bridge_rd_valid (bridge_rd_valid),
    .busy            (busy),
    .mem_address     (mem_address),
    .mem_rd          (mem_rd),
    .mem_rd_data     (mem_rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] v;
  } ev_t;

  ev_t         mq[$];
  ev_t         dq[$];
  int          cyc = 0;
  int          last_e = -1000;
  logic [31:0] last_word = '0;
  bit          started = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] dl[LAT];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] memb(logic [31:0] a);
    if (a >= 32'h10 && a <= 32'h13) return 8'h11 * 8'(a - 32'hf);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
  endfunction

  function automatic logic [31:0] exp_word(logic [31:0] a);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < 4; k++) begin
`ifdef BYTES_TO_BRIDGE_BIG_ENDIAN_EN
      w[24-8*k +: 8] = memb(a + 32'(k));
`else
      w[8*k +: 8] = memb(a + 32'(k));
`endif
    end
    return w;
  endfunction

  function automatic bit model_busy(int c);
    return c >= last_e && c < last_e + 3 + LAT;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Byte memory: request seen in a cycle is answered LAT edges later
  always @(negedge clk) begin
    for (int i = LAT - 1; i > 0; i--) dl[i] = dl[i-1];
    dl[0] = mem_address;
    mem_rd_data = memb(dl[LAT-1]);
  end

  always @(negedge clk) begin
    ev_t e;
    if (reset_n && started) begin
      if (mem_rd) begin
        if (mq.size() == 0) chk("mem_rd_spurious", 1, 0);
        else begin
          e = mq.pop_front();
          chk("mem_rd_cycle", cyc, e.cyc);
          chk("mem_address", mem_address, e.v);
        end
      end else if (mq.size() != 0 && mq[0].cyc <= cyc) begin
        e = mq.pop_front();
        chk("mem_rd_missing", 0, 1);
      end
      if (bridge_rd_valid) begin
        if (dq.size() == 0) chk("valid_spurious", 1, 0);
        else begin
          e = dq.pop_front();
          chk("valid_cycle", cyc, e.cyc);
          chk("rd_data", bridge_rd_data, e.v);
          last_word = e.v;
        end
      end else begin
        if (dq.size() != 0 && dq[0].cyc <= cyc) begin
          e = dq.pop_front();
          chk("valid_missing", 0, 1);
        end
        chk("rd_data_hold", bridge_rd_data, last_word);
      end
      chk("busy", busy, model_busy(cyc));
    end
  end

  // Called at a negedge; request is sampled on the next posedge
  task automatic req(logic [31:0] a);
    int e;
    bridge_addr = a;
    bridge_rd   = 1'b1;
    if (!model_busy(cyc)) begin
      e = cyc + 1;
      last_e = e;
      for (int k = 0; k < 4; k++) mq.push_back('{e + k, a + 32'(k)});
      dq.push_back('{e + 3 + LAT, exp_word(a)});
    end
    @(negedge clk);
    bridge_rd = 1'b0;
  endtask

  task automatic goto_cyc(int t);
    for (int i = 0; i < 200 && cyc < t; i++) @(negedge clk);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_rd_data", bridge_rd_data, 0);
    chk("rst_rd_valid", bridge_rd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_address", mem_address, 0);
  endtask

  initial begin
    logic [31:0] a;
    int e0;
    for (int i = 0; i < LAT; i++) dl[i] = '0;
    reset_n     = 1'b0;
    bridge_rd   = 1'b0;
    bridge_addr = '0;
    mem_rd_data = '0;
    repeat (2) @(negedge clk);
    chk_reset_outputs();
    #2 reset_n = 1'b1;
    @(negedge clk);
    started = 1'b1;

    req(32'h10);
    e0 = last_e;
    req(32'h80);
    goto_cyc(e0 + 3 + LAT);
    req(32'h20);
    goto_cyc(last_e + 3 + LAT + 2);
    req(32'hFFFF_FFFE);
    goto_cyc(last_e + 3 + LAT + 1);

    req(32'h10);
    @(negedge clk);
    #2;
    mq.delete();
    dq.delete();
    last_e    = -1000;
    last_word = '0;
    reset_n   = 1'b0;
    #1 chk_reset_outputs();
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (4) @(negedge clk);
    req(32'h10);

    repeat (40) begin
      repeat ($urandom_range(0, 8)) @(negedge clk);
      case ($urandom_range(0, 2))
        0:       a = $urandom;
        1:       a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
        default: a = 32'h10 + 32'($urandom_range(0, 3));
      endcase
      req(a);
    end

    for (int i = 0; i < 60 && (mq.size() != 0 || dq.size() != 0); i++)
      @(negedge clk);
    repeat (4) @(negedge clk);
    chk("drain", 32'(mq.size() + dq.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
